// File: rtl/up_down_counter_pkg.sv
// rtl/up_down_counter_pkg.sv - shared types for the up/down counter
package up_down_counter_pkg;

    // Source of the next count value when the counter is out of reset
    typedef enum logic [1:0] {
        SEL_LOAD = 2'd0,
        SEL_INC  = 2'd1,
        SEL_DEC  = 2'd2
    } step_sel_e;

endpackage

// File: rtl/up_down_counter.sv
// rtl/up_down_counter.sv - loadable modulo-2^WIDTH up/down counter
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             up_down,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count_out
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_next;
    step_sel_e        sel;

    // Next-value mux: load beats counting; wrap comes free from WIDTH-bit arithmetic
    always_comb begin
        sel        = SEL_LOAD;
        count_next = count_q;
        if (load) begin
            sel = SEL_LOAD;
        end else if (up_down) begin
            sel = SEL_INC;
        end else begin
            sel = SEL_DEC;
        end
        case (sel)
            SEL_LOAD: count_next = data_in;
            SEL_INC:  count_next = count_q + WIDTH'(1);
            SEL_DEC:  count_next = count_q - WIDTH'(1);
            default:  count_next = count_q;
        endcase
    end

    // Count register with synchronous active-low clear taking priority
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

    assign count_out = count_q;

endmodule

// File: tb/tb_up_down_counter.sv
// tb/tb_up_down_counter.sv - scoreboard bench for up_down_counter
module tb_up_down_counter;

    localparam int W    = 4;
    localparam int MODV = 1 << W;

    logic         clk;
    logic         reset;
    logic         load;
    logic         up_down;
    logic [W-1:0] data_in;
    logic [W-1:0] count_out;

    int checks = 0;
    int errors = 0;
    int model  = 0;
    logic [W-1:0] exp_q[$];
    string        name_q[$];

    up_down_counter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .up_down   (up_down),
        .data_in   (data_in),
        .count_out (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: next = 0 on reset, else loaded value, else +/-1 modulo 2^W
    function automatic int ref_next(int cur, logic r, logic l, logic ud, int d);
        if (!r) return 0;
        if (l) return d % MODV;
        if (ud) return (cur + 1) % MODV;
        return (cur + MODV - 1) % MODV;
    endfunction

    task automatic step(input logic r, input logic l, input logic ud,
                        input int d, input string nm);
        @(negedge clk);
        reset   = r;
        load    = l;
        up_down = ud;
        data_in = W'(d);
        model   = ref_next(model, r, l, ud, d);
        exp_q.push_back(W'(model));
        name_q.push_back(nm);
    endtask

    // Monitor: every edge with a pending expectation is compared after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [W-1:0] e;
                string        n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (count_out !== e) begin
                    errors++;
                    $display("FAIL %s: count_out=%h expected=%h", n, count_out, e);
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        up_down = 1'b1;
        data_in = '0;

        // Reset from arbitrary state, held with load active
        step(1'b0, 1'b0, 1'b1, 0, "reset_edge1");
        step(1'b0, 1'b0, 1'b0, 0, "reset_edge2");
        step(1'b0, 1'b1, 1'b1, 4'hA, "reset_hold_load");

        // Load then count up, then down
        step(1'b1, 1'b1, 1'b1, 4'hA, "load_A");
        step(1'b1, 1'b0, 1'b1, 0, "up_B");
        step(1'b1, 1'b0, 1'b1, 0, "up_C");
        step(1'b1, 1'b0, 1'b0, 0, "down_B");
        step(1'b1, 1'b0, 1'b0, 0, "down_A");

        // Wrap both ways
        step(1'b1, 1'b1, 1'b1, 4'hF, "load_F");
        step(1'b1, 1'b0, 1'b1, 0, "wrap_up");
        step(1'b1, 1'b1, 1'b0, 4'h0, "load_0");
        step(1'b1, 1'b0, 1'b0, 0, "wrap_down");

        // Priority: reset over load, load over count
        step(1'b0, 1'b1, 1'b1, 4'h5, "prio_reset");
        step(1'b1, 1'b1, 1'b0, 4'h5, "prio_load");
        step(1'b1, 1'b0, 1'b1, 0, "after_load_up");

        // Synchronous reset: mid-cycle drop must not change output until the edge
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (count_out !== W'(model)) begin
            errors++;
            $display("FAIL async_reset: count_out=%h expected=%h", count_out, W'(model));
        end
        model = 0;
        exp_q.push_back('0);
        name_q.push_back("sync_reset_edge");
        @(posedge clk);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic r;
            logic l;
            r = ($urandom_range(0, 19) != 0);
            l = ($urandom_range(0, 4) == 0);
            step(r, l, 1'($urandom_range(0, 1)), int'($urandom_range(0, MODV - 1)), "random");
        end

        // Drain with a bounded wait
        begin
            int budget;
            budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #2;
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: pending=%0d expected=0", exp_q.size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/up_down_counter.md
UP_DOWN_COUNTER -- requirements
Module: up_down_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter and data width in bits (legal range 1..32).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-low (reset=0 clears on next rising clk).
REQ-004 Port: load  input  1  active-high parallel load enable.
REQ-005 Port: up_down  input  1  direction select; 1 = count up, 0 = count down.
REQ-006 Port: data_in  input  WIDTH  parallel load value.
REQ-007 Port: count_out  output  WIDTH  current count, driven directly from the count register (no combinational path from inputs).
REQ-008 Port order SHALL be clk, reset, load, up_down, data_in, count_out, so positional instantiation works.

Function
REQ-009 Per rising clk edge, priority SHALL be: reset, then load, then count.
REQ-010 reset=0: count_out SHALL become 0 on that edge, regardless of load/up_down/data_in.
REQ-011 reset=1, load=1: count_out SHALL become data_in on that edge; no count step that cycle.
REQ-012 reset=1, load=0, up_down=1: count_out SHALL become count_out+1 modulo 2^WIDTH.
REQ-013 reset=1, load=0, up_down=0: count_out SHALL become count_out-1 modulo 2^WIDTH.
REQ-014 Up wrap: all-ones (4'hF at WIDTH=4) SHALL step to 0; no saturation, no flag.
REQ-015 Down wrap: 0 SHALL step to all-ones (4'hF at WIDTH=4).
REQ-016 Counter SHALL count every cycle when not reset/loading; no separate enable.
REQ-017 Latency: every input effect SHALL appear on count_out exactly one clk edge after sampling; no output changes between edges.
REQ-018 Direction change SHALL take effect on the first edge sampling the new up_down value; no idle cycle.
REQ-019 Load of any value, including all-ones or 0, SHALL be accepted; next step counts from loaded value in the sampled direction.

Reset
REQ-020 Reset SHALL be synchronous only: asserting reset without a clk edge SHALL NOT change count_out.
REQ-021 Reset held low for N edges SHALL keep count_out=0 for all N edges; first edge with reset=1 applies load/count normally.
REQ-022 Reset asserted mid-count or simultaneously with load SHALL win; count_out=0 after that edge.
REQ-023 Before the first reset edge count_out is unspecified (X permitted in simulation); benches SHALL apply reset first.

Structure
REQ-024 No shared package required; WIDTH is the only configurable constant and stays a module parameter.
REQ-025 Single module, one clocked process, no sub-modules; next-value mux (reset/load/inc/dec) SHALL be expressed as combinational next-state logic feeding one WIDTH-bit register.
REQ-026 No latches, no asynchronous logic, no gated clocks.

Verification
REQ-027 Reset: reset=0 for 2 edges from arbitrary state -> count_out=0; stays 0 while reset=0 even with load=1, data_in=4'hA.
REQ-028 Load then count up: reset=1, load=1, data_in=4'hA one edge -> 4'hA; load=0, up_down=1 two edges -> 4'hB, 4'hC.
REQ-029 Count down: from 4'hC, up_down=0 two edges -> 4'hB, 4'hA.
REQ-030 Wrap: load 4'hF, up_down=1 -> next 4'h0; load 4'h0, up_down=0 -> next 4'hF.
REQ-031 Priority: reset=0 with load=1, data_in=4'h5 -> 0; reset=1, load=1, up_down=0, data_in=4'h5 -> 4'h5 (no decrement).
REQ-032 Synchronicity: drop reset to 0 mid-cycle -> count_out unchanged until next rising clk, then 0.
